// File: rtl/trng_collector.sv
// trng_collector: gates the ring-oscillator TRNG and packs Von Neumann debiased bits into WIDTH-bit words.
// Optional build macro TRNG_COLLECTOR_RCT_EN adds a sticky repetition-count health test on raw samples.
module trng_collector #(
  parameter int WIDTH      = 8,
  parameter int SAMPLE_DIV = 4,
  parameter int WARMUP     = 16,
  parameter int RCT_LIMIT  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             random_in,
  output logic             osc_run,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             error
);

  // Handshake: a word moves on any cycle where valid & ready are both high; while valid & !ready
  // data is frozen; valid falls after a transfer unless a new word is loaded on the same edge.

  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;
  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV + 1) : 1;
  localparam int CNT_W  = $clog2(WIDTH + 1);

  if (WIDTH < 2 || SAMPLE_DIV < 1 || WARMUP < 1 || RCT_LIMIT < 2) begin : g_param_check
    $error("trng_collector: illegal parameter value");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_COLLECT = 2'd2,
    ST_FULL    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               pair_vld_q, pair_vld_d;
  logic               pair_bit_q, pair_bit_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               osc_run_q, osc_run_d;

  logic               xfer;
  logic               sample_take;
  logic               emit;
  logic               rct_trip;
  logic [WIDTH-1:0]   word;

  assign xfer        = valid_q & ready;
  assign sample_take = (state_q == ST_COLLECT) && en && (div_cnt_q == DIV_W'(SAMPLE_DIV - 1));
  assign emit        = sample_take && pair_vld_q && (random_in != pair_bit_q);
  assign word        = {sreg_q[WIDTH-2:0], pair_bit_q};

  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    div_cnt_d  = div_cnt_q;
    pair_vld_d = pair_vld_q;
    pair_bit_d = pair_bit_q;
    sreg_d     = sreg_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    valid_d    = valid_q & ~ready;

    if (!en && state_q != ST_IDLE) begin
      // Dropping enable throws away partial entropy; an already loaded word stays offered.
      state_d    = ST_IDLE;
      sreg_d     = '0;
      bit_cnt_d  = '0;
      pair_vld_d = 1'b0;
      pair_bit_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_d    = ST_WARMUP;
            warm_cnt_d = '0;
          end
        end

        ST_WARMUP: begin
          if (warm_cnt_q == WARM_W'(WARMUP - 1)) begin
            state_d    = ST_COLLECT;
            div_cnt_d  = '0;
            pair_vld_d = 1'b0;
          end else begin
            warm_cnt_d = warm_cnt_q + 1'b1;
          end
        end

        ST_COLLECT: begin
          if (sample_take) begin
            div_cnt_d = '0;
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end

          if (sample_take) begin
            if (!pair_vld_q) begin
              pair_vld_d = 1'b1;
              pair_bit_d = random_in;
            end else begin
              pair_vld_d = 1'b0;
            end
          end

          if (rct_trip) begin
            sreg_d     = '0;
            bit_cnt_d  = '0;
            pair_vld_d = 1'b0;
          end else if (emit) begin
            sreg_d = word;
            if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
              if (!valid_q || ready) begin
                data_d    = word;
                valid_d   = 1'b1;
                bit_cnt_d = '0;
              end else begin
                bit_cnt_d = CNT_W'(WIDTH);
                state_d   = ST_FULL;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end

        ST_FULL: begin
          if (xfer) begin
            data_d     = sreg_q;
            valid_d    = 1'b1;
            bit_cnt_d  = '0;
            state_d    = ST_WARMUP;
            warm_cnt_d = '0;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    osc_run_d = (state_d == ST_WARMUP) || (state_d == ST_COLLECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      warm_cnt_q <= '0;
      div_cnt_q  <= '0;
      pair_vld_q <= 1'b0;
      pair_bit_q <= 1'b0;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      osc_run_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      div_cnt_q  <= div_cnt_d;
      pair_vld_q <= pair_vld_d;
      pair_bit_q <= pair_bit_d;
      sreg_q     <= sreg_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      osc_run_q  <= osc_run_d;
    end
  end

`ifdef TRNG_COLLECTOR_RCT_EN
  localparam int RCT_W = $clog2(RCT_LIMIT + 1);

  logic [RCT_W-1:0] rct_cnt_q, rct_cnt_d;
  logic [RCT_W-1:0] rct_run;
  logic             rct_last_q;
  logic             error_q;

  // rct_cnt_q == 0 means no run in progress, so the next sample always starts a run of one.
  always_comb begin
    rct_cnt_d = rct_cnt_q;
    rct_trip  = 1'b0;
    rct_run   = ((rct_cnt_q != '0) && (random_in == rct_last_q)) ? rct_cnt_q + 1'b1 : RCT_W'(1);
    if (sample_take) begin
      if (rct_run == RCT_W'(RCT_LIMIT)) begin
        rct_trip  = 1'b1;
        rct_cnt_d = '0;
      end else begin
        rct_cnt_d = rct_run;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rct_cnt_q  <= '0;
      rct_last_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      rct_cnt_q <= rct_cnt_d;
      if (sample_take) begin
        rct_last_q <= random_in;
      end
      if (rct_trip) begin
        error_q <= 1'b1;
      end
    end
  end

  assign error = error_q;
`else
  assign rct_trip = 1'b0;
  assign error    = 1'b0;
`endif

  assign osc_run = osc_run_q;
  assign data    = data_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_trng_collector.sv
// tb_trng_collector: directed stimulus for trng_collector, checked every cycle against a queue-based model.
`timescale 1ns/1ps
module tb_trng_collector;

  localparam int WIDTH      = 8;
  localparam int SAMPLE_DIV = 1;
  localparam int WARMUP     = 4;
  localparam int RCT_LIMIT  = 32;
`ifdef TRNG_COLLECTOR_RCT_EN
  localparam bit RCT_ON = 1'b1;
`else
  localparam bit RCT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             random_in = 1'b0;
  logic             ready = 1'b0;
  logic             osc_run;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             error;

  trng_collector #(
    .WIDTH(WIDTH), .SAMPLE_DIV(SAMPLE_DIV), .WARMUP(WARMUP), .RCT_LIMIT(RCT_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .random_in(random_in), .osc_run(osc_run),
    .data(data), .valid(valid), .ready(ready), .error(error)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit               m_osc, m_stalled, m_valid, m_err, m_last;
  int               m_warm_left, m_div, m_run;
  logic [WIDTH-1:0] m_data;
  bit               pair_q[$];
  bit               bits_q[$];

  function automatic logic [WIDTH-1:0] pack_bits();
    logic [WIDTH-1:0] w = '0;
    foreach (bits_q[i]) w = {w[WIDTH-2:0], bits_q[i]};
    return w;
  endfunction

  task automatic model_reset();
    m_osc = 0; m_stalled = 0; m_valid = 0; m_err = 0; m_last = 0;
    m_warm_left = 0; m_div = 0; m_run = 0; m_data = '0;
    pair_q.delete(); bits_q.delete();
  endtask

  task automatic model_step();
    bit xfer, loaded, s, tripped;
    xfer = m_valid && ready;
    loaded = 0;
    tripped = 0;
    if (!en && (m_osc || m_stalled)) begin
      m_osc = 0; m_stalled = 0;
      pair_q.delete(); bits_q.delete();
    end else if (m_stalled) begin
      if (xfer) begin
        m_data = pack_bits(); bits_q.delete(); loaded = 1;
        m_stalled = 0; m_osc = 1; m_warm_left = WARMUP;
      end
    end else if (!m_osc) begin
      if (en) begin m_osc = 1; m_warm_left = WARMUP; end
    end else if (m_warm_left > 0) begin
      m_warm_left--;
      if (m_warm_left == 0) begin m_div = 0; pair_q.delete(); end
    end else begin
      m_div++;
      if (m_div == SAMPLE_DIV) begin
        m_div = 0;
        s = random_in;
        if (RCT_ON) begin
          m_run = (m_run > 0 && s == m_last) ? m_run + 1 : 1;
          m_last = s;
          if (m_run == RCT_LIMIT) begin
            m_err = 1; m_run = 0; tripped = 1;
            pair_q.delete(); bits_q.delete();
          end
        end
        if (!tripped) begin
          pair_q.push_back(s);
          if (pair_q.size() == 2) begin
            if (pair_q[0] != pair_q[1]) bits_q.push_back(pair_q[0]);
            pair_q.delete();
          end
          if (bits_q.size() == WIDTH) begin
            if (!m_valid || xfer) begin
              m_data = pack_bits(); bits_q.delete(); loaded = 1;
            end else begin
              m_stalled = 1; m_osc = 0;
            end
          end
        end
      end
    end
    if (loaded) m_valid = 1;
    else if (xfer) m_valid = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_on = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      check("osc_run", {31'd0, osc_run}, {31'd0, m_osc});
      check("data", {24'd0, data}, {24'd0, m_data});
      check("valid", {31'd0, valid}, {31'd0, m_valid});
      check("error", {31'd0, error}, {31'd0, m_err});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_collect();
    int t = 0;
    while (!(m_osc && m_warm_left == 0)) begin
      @(negedge clk);
      t++;
      if (t > 100) begin
        n_checks++;
        $display("FAIL wait_collect: got no collection after %0d cycles required <= 100", t);
        break;
      end
    end
  endtask

  // Drives v[n-1:0] MSB first, one raw sample per cycle; ready follows r bit for bit.
  task automatic send(input logic [63:0] v, input int n, input logic [63:0] r);
    wait_collect();
    for (int i = n - 1; i >= 0; i--) begin
      random_in = v[i];
      ready = r[i];
      @(negedge clk);
    end
    ready = 1'b0;
    random_in = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; en = 1'b1; ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      random_in = ~random_in;
    end
    check("rst_data", {24'd0, data}, 32'h0);
    check("rst_valid", {31'd0, valid}, 32'h0);
    check("rst_osc_run", {31'd0, osc_run}, 32'h0);
    check("rst_error", {31'd0, error}, 32'h0);
    random_in = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("osc_after_en", {31'd0, osc_run}, 32'h1);
    chk_on = 1;

    // Debias: (01 00 10 11) x4 -> bits 0,1 per group -> 8'h55
    send(64'h4B4B4B4B, 32, 64'h0);
    check("debias_data", {24'd0, data}, 32'h55);
    check("debias_valid", {31'd0, valid}, 32'h1);

    // Backpressure: second word 8'hA3 arrives while 8'h55 is unconsumed
    send(64'h995A, 16, 64'h0);
    check("bp_osc_off", {31'd0, osc_run}, 32'h0);
    check("bp_data_hold", {24'd0, data}, 32'h55);
    @(negedge clk);
    @(negedge clk);
    check("bp_still_hold", {24'd0, data}, 32'h55);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("bp_second_data", {24'd0, data}, 32'hA3);
    check("bp_second_valid", {31'd0, valid}, 32'h1);
    check("bp_osc_restart", {31'd0, osc_run}, 32'h1);

    // Simultaneous: 8'h3C completes on the same edge that 8'hA3 is taken
    send(64'h5AA5, 16, 64'h0001);
    check("simul_data", {24'd0, data}, 32'h3C);
    check("simul_valid", {31'd0, valid}, 32'h1);

    // Enable drop after 5 emitted bits (ready on first sample consumes 8'h3C)
    send(64'h269, 10, 64'h200);
    en = 1'b0;
    @(negedge clk);
    check("endrop_osc_off", {31'd0, osc_run}, 32'h0);
    check("endrop_valid", {31'd0, valid}, 32'h0);
    @(negedge clk);
    en = 1'b1;
    send(64'hAAAA, 16, 64'h0);
    check("reen_data", {24'd0, data}, 32'hFF);
    check("reen_valid", {31'd0, valid}, 32'h1);

    // Health test: 32 identical raw ones, then toggling input
    send(64'hFFFFFFFF, 32, 64'h80000000);
    check("rct_error", {31'd0, error}, {31'd0, RCT_ON});
    send(64'h2AA, 10, 64'h0);
    check("rct_error_sticky", {31'd0, error}, {31'd0, RCT_ON});
    check("rct_valid", {31'd0, valid}, 32'h0);

    @(negedge clk);
    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trng_collector.md
Name: trng_collector

Overview:
- Consumes the 1-bit sampled output of the ring-oscillator TRNG and produces debiased WIDTH-bit random words behind a valid/ready handshake.
- Drives the oscillator run control, so the oscillator is off whenever no entropy is needed. This saves power and limits supply noise coupling into the life-grid logic.
- Sits between the TRNG sampler and any random-seed consumer, for example the grid randomiser.

Parameters:
WIDTH, 8, output word width in bits (>=2)
SAMPLE_DIV, 4, clk cycles between raw samples (>=1); decimates correlated consecutive samples
WARMUP, 16, clk cycles of oscillator run before the first sample is taken (>=1)
RCT_LIMIT, 32, consecutive identical raw samples that trip the health test (feature only)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active low
en  input  1  collection enable
random_in  input  1  synchronised random bit from the TRNG sampler
osc_run  output  1  to the TRNG stop input; 1 = oscillate, 0 = halted
data  output  WIDTH  random word
valid  output  1  data holds an unconsumed word
ready  input  1  consumer accepts data
error  output  1  sticky health-test failure (feature only; tied 0 otherwise)

Behaviour:
- One clock domain. Reset is asynchronous and active-low: rst_n low sets data=0, valid=0, osc_run=0, error=0, state IDLE, and clears all counters, the shift register and the pair latch.
- All outputs are registered.
- States:
  - IDLE: osc_run=0. en=1 -> WARMUP with warm counter cleared.
  - WARMUP: osc_run=1. After WARMUP cycles -> COLLECT, with the divider and the pair latch cleared.
  - COLLECT: osc_run=1. The divider counts 0..SAMPLE_DIV-1, and random_in is sampled when the divider equals SAMPLE_DIV-1. With SAMPLE_DIV=1 a sample is taken every cycle.
  - FULL: osc_run=0. The shift register is complete and the data register is occupied.
- Von Neumann debias:
  - Samples are taken in pairs (a,b).
  - a!=b: emit a.
  - a==b: discard both.
  - Pairing is non-overlapping.
- Word assembly:
  - Each emitted bit shifts into sreg at bit 0; earlier bits move toward the MSB.
  - A bit counter reaches WIDTH -> word complete.
- Word complete in COLLECT:
  - If valid=0, or valid&ready in the same cycle: data<=sreg, valid<=1, counter cleared, stay in COLLECT.
  - Otherwise -> FULL.
- FULL:
  - On valid&ready: data<=sreg, valid stays 1, counter cleared, -> WARMUP. The oscillator restarts with a full warm-up.
- Handshake:
  - Transfer occurs on valid&ready.
  - data is stable while valid&!ready.
  - valid drops the cycle after a transfer unless a new word is loaded in the same cycle.
- en=0 in any non-IDLE state:
  - Next cycle: state IDLE, osc_run=0.
  - The partial sreg, bit counter and pair latch are discarded.
  - data/valid are retained until consumed.
- en re-asserted: a full WARMUP is applied again, and the word is assembled from new bits only.
- Latency from en rise to the first sample: 1 + WARMUP + SAMPLE_DIV cycles.

Optional Feature:
- Macro TRNG_COLLECTOR_RCT_EN enables a repetition-count health test on raw samples. This runs before debiasing.
- The test counts consecutive equal samples. When the count reaches RCT_LIMIT:
  - error<=1 (sticky until reset).
  - sreg, bit counter and pair latch are cleared.
  - The count restarts.
- Without the macro: there is no counter logic, and error is constant 0.
- data/valid behaviour is otherwise identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with en=1 and random_in toggling -> data=0, valid=0, osc_run=0, error=0. After release, osc_run=1 one cycle after en is seen.
- Debias (WIDTH=8, SAMPLE_DIV=1, WARMUP=4): sample pairs 01,10 repeated 4 times with 00 and 11 interleaved -> data=8'h55, valid=1. The 00/11 pairs add no bits.
- Backpressure: ready=0 while two words are produced -> after the second completes, osc_run=0 and data holds the first word. Assert ready for 1 cycle -> data=second word, valid=1, then osc_run=1 and 4 warm-up cycles before the next sample.
- Simultaneous event: word completes in the same cycle as valid&ready -> data updates to the new word and valid stays 1 with no gap.
- Enable drop: en=0 after 5 emitted bits -> osc_run=0 next cycle. Re-enable and feed 8 debiased 1s -> data=8'hFF, with no stale bits.
- Feature on (RCT_LIMIT=32): random_in held at 1 for 32 samples -> error=1 and remains set after the input resumes toggling. Feature off -> error=0.
